// File: rtl/tb_ctrl_periph.sv
// tb_ctrl_periph
// ---------------
// Memory-mapped control peripheral for the core testbench. It sits on the
// data bus next to the RAM model and decodes a 256-byte register window.
//
// Register map (word offsets inside the window):
//   0x00 STATUS    W  123456789 -> tests_passed_o, 1 -> tests_failed_o
//   0x04 EXIT      W  exit_value_o <= wdata, exit_valid_o <= 1
//   0x08 STDOUT    W  push wdata[7:0]; held (gnt_o = 0) while FIFO full
//   0x0C TIMER     RW load down-counter (0 cancels); expiry sets irq line
//   0x10 IRQ_SET   W  irq_o |= wdata
//   0x14 IRQ_PEND  R  irq_o, zero-extended
//   0x18 DBG_DELAY W  start delayed debug_req_o pulse
//   0x1C CYCLE     R  free-running cycle counter
//   others / reads of write-only registers return 0 with no side effect.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_i/gnt_o/addr_i/we_i/be_i/wdata_i/rdata_o/rvalid_o   data bus slave
//   stdout_data_o/valid_o/ready_i                           stdout byte stream
//   irq_o, irq_ack_i, irq_id_i   level interrupts and acknowledge
//   debug_req_o                  debug request pulse
//   tests_passed_o/tests_failed_o/exit_valid_o/exit_value_o  test status
//
// Optional feature: define TB_CTRL_RANDOM_STALL_EN to add a 16-bit LFSR
// (seed 16'hACE1) that withholds gnt_o whenever lfsr[1:0] == 2'b00.
module tb_ctrl_periph #(
    parameter logic [31:0] BASE_ADDR     = 32'h1500_0000,
    parameter int          NUM_IRQ       = 32,
    parameter int          TIMER_IRQ_ID  = 7,
    parameter int          STDOUT_DEPTH  = 8,
    parameter int          DBG_PULSE_LEN = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_i,
    output logic               gnt_o,
    input  logic [31:0]        addr_i,
    input  logic               we_i,
    input  logic [3:0]         be_i,
    input  logic [31:0]        wdata_i,
    output logic [31:0]        rdata_o,
    output logic               rvalid_o,
    output logic [7:0]         stdout_data_o,
    output logic               stdout_valid_o,
    input  logic               stdout_ready_i,
    output logic [NUM_IRQ-1:0] irq_o,
    input  logic               irq_ack_i,
    input  logic [4:0]         irq_id_i,
    output logic               debug_req_o,
    output logic               tests_passed_o,
    output logic               tests_failed_o,
    output logic               exit_valid_o,
    output logic [31:0]        exit_value_o
);

    localparam int PTR_W  = $clog2(STDOUT_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int PLEN_W = (DBG_PULSE_LEN > 1) ? $clog2(DBG_PULSE_LEN) : 1;

    localparam logic [5:0] OFF_STATUS   = 6'h00;
    localparam logic [5:0] OFF_EXIT     = 6'h01;
    localparam logic [5:0] OFF_STDOUT   = 6'h02;
    localparam logic [5:0] OFF_TIMER    = 6'h03;
    localparam logic [5:0] OFF_IRQ_SET  = 6'h04;
    localparam logic [5:0] OFF_IRQ_PEND = 6'h05;
    localparam logic [5:0] OFF_DBG      = 6'h06;
    localparam logic [5:0] OFF_CYCLE    = 6'h07;

    localparam logic [31:0]        PASS_CODE   = 32'd123456789;
    localparam logic [31:0]        FAIL_CODE   = 32'd1;
    localparam logic [NUM_IRQ-1:0] IRQ_ONE     = NUM_IRQ'(1'b1);
    localparam logic [31:0]        NUM_IRQ_U   = 32'(NUM_IRQ);
    localparam logic [CNT_W-1:0]   FIFO_FULL   = CNT_W'(STDOUT_DEPTH);
    localparam logic [PLEN_W-1:0]  PULSE_INIT  = PLEN_W'(DBG_PULSE_LEN - 1);

    typedef enum logic [1:0] {
        DBG_IDLE  = 2'd0,
        DBG_WAIT  = 2'd1,
        DBG_PULSE = 2'd2
    } dbg_state_e;

    // Address bits outside the word index, the byte enables and the base are
    // decoded externally; collected here so the intent is explicit.
    logic unused_s;
    assign unused_s = ^{be_i, addr_i[31:8], addr_i[1:0], BASE_ADDR};

    logic [5:0] word_s;
    assign word_s = addr_i[7:2];

    // ------------------------------------------------------------------
    // Optional grant stall
    // ------------------------------------------------------------------
    logic stall_s;
`ifdef TB_CTRL_RANDOM_STALL_EN
    logic [15:0] lfsr_r;

    // Fibonacci LFSR x^16+x^14+x^13+x^11, advanced every cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_r <= 16'hACE1;
        end else begin
            lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
        end
    end

    assign stall_s = (lfsr_r[1:0] == 2'b00);
`else
    assign stall_s = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Bus decode and grant
    // ------------------------------------------------------------------
    logic [7:0]       fifo_mem_r [STDOUT_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0] fifo_cnt_r, fifo_cnt_next_s;
    logic             stdout_valid_r;
    logic             pop_s, push_s, stdout_req_s, gnt_s, wr_s, rd_s;

    assign pop_s        = stdout_valid_r & stdout_ready_i;
    assign stdout_req_s = req_i & we_i & (word_s == OFF_STDOUT);
    // A pop in the same cycle frees the slot, so a full FIFO still grants.
    assign gnt_s        = req_i & ~stall_s &
                          ~(stdout_req_s & (fifo_cnt_r == FIFO_FULL) & ~pop_s);
    assign wr_s         = gnt_s & we_i;
    assign rd_s         = gnt_s & ~we_i;
    assign push_s       = gnt_s & stdout_req_s;
    assign gnt_o        = gnt_s;

    // ------------------------------------------------------------------
    // Stdout FIFO
    // ------------------------------------------------------------------
    // Occupancy after this cycle's push/pop
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   fifo_cnt_next_s = fifo_cnt_r + CNT_W'(1);
            2'b01:   fifo_cnt_next_s = fifo_cnt_r - CNT_W'(1);
            default: fifo_cnt_next_s = fifo_cnt_r;
        endcase
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= wdata_i[7:0];
        end
    end

    // FIFO pointers, occupancy and valid flag (pointers wrap by width)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r       <= PTR_W'(0);
            rd_ptr_r       <= PTR_W'(0);
            fifo_cnt_r     <= CNT_W'(0);
            stdout_valid_r <= 1'b0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            fifo_cnt_r     <= fifo_cnt_next_s;
            stdout_valid_r <= (fifo_cnt_next_s != CNT_W'(0));
        end
    end

    assign stdout_valid_o = stdout_valid_r;
    assign stdout_data_o  = fifo_mem_r[rd_ptr_r];

    // ------------------------------------------------------------------
    // Status, exit and cycle counter
    // ------------------------------------------------------------------
    logic        passed_r, failed_r, exit_valid_r;
    logic [31:0] exit_value_r, cycle_r;

    // Sticky pass/fail/exit flags, exit code and free-running cycle count
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            passed_r     <= 1'b0;
            failed_r     <= 1'b0;
            exit_valid_r <= 1'b0;
            exit_value_r <= 32'd0;
            cycle_r      <= 32'd0;
        end else begin
            cycle_r <= cycle_r + 32'd1;
            if (wr_s && word_s == OFF_STATUS && wdata_i == PASS_CODE) passed_r <= 1'b1;
            if (wr_s && word_s == OFF_STATUS && wdata_i == FAIL_CODE) failed_r <= 1'b1;
            if (wr_s && word_s == OFF_EXIT) begin
                exit_valid_r <= 1'b1;
                exit_value_r <= wdata_i;
            end
        end
    end

    assign tests_passed_o = passed_r;
    assign tests_failed_o = failed_r;
    assign exit_valid_o   = exit_valid_r;
    assign exit_value_o   = exit_value_r;

    // ------------------------------------------------------------------
    // Timer and interrupts
    // ------------------------------------------------------------------
    logic [31:0]        timer_r, timer_next_s;
    logic               timer_wr_s, timer_expire_s;
    logic [NUM_IRQ-1:0] irq_r, irq_clr_s, irq_set_s, irq_tmr_s;

    assign timer_wr_s     = wr_s & (word_s == OFF_TIMER);
    // A reload in the final cycle supersedes the expiry.
    assign timer_expire_s = (timer_r == 32'd1) & ~timer_wr_s;

    // Timer next value: write loads/cancels, otherwise count down to zero
    always_comb begin
        if (timer_wr_s) begin
            timer_next_s = wdata_i;
        end else if (timer_r != 32'd0) begin
            timer_next_s = timer_r - 32'd1;
        end else begin
            timer_next_s = timer_r;
        end
    end

    // Interrupt clear/set masks; sets are applied after clears so they win
    always_comb begin
        if (irq_ack_i && ({27'd0, irq_id_i} < NUM_IRQ_U)) begin
            irq_clr_s = IRQ_ONE << irq_id_i;
        end else begin
            irq_clr_s = '0;
        end
        if (wr_s && word_s == OFF_IRQ_SET) begin
            irq_set_s = wdata_i[NUM_IRQ-1:0];
        end else begin
            irq_set_s = '0;
        end
        if (timer_expire_s) begin
            irq_tmr_s = IRQ_ONE << TIMER_IRQ_ID;
        end else begin
            irq_tmr_s = '0;
        end
    end

    // Timer count and interrupt lines
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timer_r <= 32'd0;
            irq_r   <= '0;
        end else begin
            timer_r <= timer_next_s;
            irq_r   <= (irq_r & ~irq_clr_s) | irq_set_s | irq_tmr_s;
        end
    end

    assign irq_o = irq_r;

    // ------------------------------------------------------------------
    // Debug request FSM
    // ------------------------------------------------------------------
    dbg_state_e        dbg_state_r, dbg_state_next_s;
    logic [31:0]       dbg_cnt_r, dbg_cnt_next_s;
    logic [PLEN_W-1:0] dbg_pcnt_r, dbg_pcnt_next_s;
    logic              dbg_wr_s, debug_req_s, debug_req_r;

    assign dbg_wr_s = wr_s & (word_s == OFF_DBG);

    // FSM state and counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dbg_state_r <= DBG_IDLE;
            dbg_cnt_r   <= 32'd0;
            dbg_pcnt_r  <= PLEN_W'(0);
            debug_req_r <= 1'b0;
        end else begin
            dbg_state_r <= dbg_state_next_s;
            dbg_cnt_r   <= dbg_cnt_next_s;
            dbg_pcnt_r  <= dbg_pcnt_next_s;
            debug_req_r <= debug_req_s;
        end
    end

    // FSM next state; a DBG_DELAY write restarts from any state
    always_comb begin
        dbg_state_next_s = dbg_state_r;
        dbg_cnt_next_s   = dbg_cnt_r;
        dbg_pcnt_next_s  = dbg_pcnt_r;
        if (dbg_wr_s) begin
            if (wdata_i == 32'd0) begin
                dbg_state_next_s = DBG_PULSE;
                dbg_pcnt_next_s  = PULSE_INIT;
            end else begin
                dbg_state_next_s = DBG_WAIT;
                dbg_cnt_next_s   = wdata_i;
            end
        end else begin
            case (dbg_state_r)
                DBG_IDLE: begin
                    dbg_state_next_s = DBG_IDLE;
                end
                DBG_WAIT: begin
                    if (dbg_cnt_r == 32'd1) begin
                        dbg_state_next_s = DBG_PULSE;
                        dbg_pcnt_next_s  = PULSE_INIT;
                    end else begin
                        dbg_cnt_next_s = dbg_cnt_r - 32'd1;
                    end
                end
                DBG_PULSE: begin
                    if (dbg_pcnt_r == PLEN_W'(0)) begin
                        dbg_state_next_s = DBG_IDLE;
                    end else begin
                        dbg_pcnt_next_s = dbg_pcnt_r - PLEN_W'(1);
                    end
                end
                default: begin
                    dbg_state_next_s = DBG_IDLE;
                end
            endcase
        end
    end

    // FSM output, decoded from the next state so the pin itself is a flop
    always_comb begin
        debug_req_s = (dbg_state_next_s == DBG_PULSE);
    end

    assign debug_req_o = debug_req_r;

    // ------------------------------------------------------------------
    // Read data and response
    // ------------------------------------------------------------------
    logic [31:0] irq_ext_s, rd_mux_s, rdata_r;
    logic        rvalid_r;

    // Read mux; write-only and unmapped offsets read as zero
    always_comb begin
        irq_ext_s                = 32'd0;
        irq_ext_s[NUM_IRQ-1:0]   = irq_r;
        case (word_s)
            OFF_TIMER:    rd_mux_s = timer_r;
            OFF_IRQ_PEND: rd_mux_s = irq_ext_s;
            OFF_CYCLE:    rd_mux_s = cycle_r;
            default:      rd_mux_s = 32'd0;
        endcase
    end

    // One-cycle response after every grant; rdata is zero outside rvalid
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_r <= 1'b0;
            rdata_r  <= 32'd0;
        end else begin
            rvalid_r <= gnt_s;
            rdata_r  <= rd_s ? rd_mux_s : 32'd0;
        end
    end

    assign rvalid_o = rvalid_r;
    assign rdata_o  = rdata_r;

endmodule
